dense_out_layer: RTL and testbench

Final fully-connected layer of the ML classifier path. Consumes a stream of signed 8-bit features, one per cycle, and multiply-accumulates each feature against a row of per-class signed 8-bit weights fetched from an external synchronous weight memory. After N_IN features it applies bias and ReLU, then presents N_OUT non-negative 32-bit class scores on a valid/ready port. That port feeds the combinational `argmax` stage directly.

---
 rtl/ml_pkg.sv | 18 +
 rtl/mac_lane.sv | 30 +++
 rtl/dense_out_layer.sv | 106 ++++++++++
 tb/tb_dense_out_layer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ml_pkg.sv
// Shared types and helpers for the ML classifier datapath (dense layer, argmax).
package ml_pkg;

    localparam int FEAT_W  = 8;
    localparam int WGT_W   = 8;
    localparam int SCORE_W = 32;

    typedef enum logic [1:0] {
        ACC,
        DRAIN,
        OUT
    } state_t;

    function automatic logic [SCORE_W-1:0] relu(input logic signed [SCORE_W-1:0] x);
        return x[SCORE_W-1] ? '0 : x;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One signed multiply-accumulate lane; load selects bias as the base instead of the running sum.
module mac_lane
    import ml_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      load,
    input  logic signed [FEAT_W-1:0]  feat,
    input  logic signed [WGT_W-1:0]   wgt,
    input  logic signed [SCORE_W-1:0] bias,
    output logic signed [SCORE_W-1:0] acc
);

    logic signed [FEAT_W+WGT_W-1:0] prod;
    logic signed [SCORE_W-1:0]      base;

    // Size casts keep signedness, so both operands are sign-extended before the multiply.
    assign prod = (FEAT_W+WGT_W)'(feat) * (FEAT_W+WGT_W)'(wgt);
    assign base = load ? bias : acc;

    // NOTE: sequential state uses non-blocking assignment so every lane samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            acc <= '0;
        else if (en)
            acc <= base + SCORE_W'(prod);
    end

endmodule

// File: rtl/dense_out_layer.sv
// Final dense layer: streams features against weight rows, adds bias, applies ReLU, emits class scores.
module dense_out_layer
    import ml_pkg::*;
#(
    parameter int N_IN  = 16,
    parameter int N_OUT = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [FEAT_W-1:0]    in_data,
    input  logic                        in_last,
    output logic [$clog2(N_IN)-1:0]     w_addr,
    input  logic [WGT_W*N_OUT-1:0]      w_data,
    input  logic signed [SCORE_W-1:0]   bias [0:N_OUT-1],
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SCORE_W-1:0]          out_scores [0:N_OUT-1],
    output logic                        err_len
);

    localparam int              AW   = $clog2(N_IN);
    localparam logic [AW-1:0]   LAST = AW'(N_IN - 1);

    state_t                    state;
    logic [AW-1:0]             cnt;
    logic signed [FEAT_W-1:0]  feat_q;
    logic                      mac_en;
    logic                      first_q;
    logic                      accept;
    logic signed [SCORE_W-1:0] acc [0:N_OUT-1];

    assign accept = in_valid & in_ready;
    assign w_addr = cnt;

    // Stage 1 registers the feature; its weight row lands on w_data the next cycle for stage 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACC;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            feat_q    <= '0;
            mac_en    <= 1'b0;
            first_q   <= 1'b0;
            err_len   <= 1'b0;
        end else begin
            mac_en <= 1'b0;
            case (state)
                ACC: begin
                    if (accept) begin
                        feat_q  <= in_data;
                        mac_en  <= 1'b1;
                        first_q <= (cnt == '0);
                        if (in_last != (cnt == LAST))
                            err_len <= 1'b1;
                        if (cnt == LAST) begin
                            cnt      <= '0;
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    state     <= OUT;
                    out_valid <= 1'b1;
                end
                OUT: begin
                    if (out_ready) begin
                        state     <= ACC;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ACC;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_lane
        mac_lane u_lane (
            .clk  (clk),
            .rst  (rst),
            .en   (mac_en),
            .load (first_q),
            .feat (feat_q),
            .wgt  (w_data[WGT_W*k +: WGT_W]),
            .bias (bias[k]),
            .acc  (acc[k])
        );
    end

    // NOTE: every element is assigned on every pass, so this stays a pure mux with no latch.
    always_comb begin
        for (int k = 0; k < N_OUT; k++)
            out_scores[k] = out_valid ? relu(acc[k]) : '0;
    end

endmodule

// File: tb/tb_dense_out_layer.sv
// Directed bench for dense_out_layer with N_IN=4, N_OUT=8 and a synchronous weight memory model.
module tb_dense_out_layer;
    import ml_pkg::*;

    localparam int N_IN  = 4;
    localparam int N_OUT = 8;
    localparam int AW    = $clog2(N_IN);

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      in_valid = 1'b0;
    logic                      in_ready;
    logic signed [FEAT_W-1:0]  in_data = '0;
    logic                      in_last = 1'b0;
    logic [AW-1:0]             w_addr;
    logic [WGT_W*N_OUT-1:0]    w_data = '0;
    logic signed [SCORE_W-1:0] bias [0:N_OUT-1];
    logic                      out_valid;
    logic                      out_ready = 1'b1;
    logic [SCORE_W-1:0]        out_scores [0:N_OUT-1];
    logic                      err_len;

    logic [WGT_W*N_OUT-1:0]    wmem [0:N_IN-1];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) w_data <= wmem[w_addr];

    dense_out_layer #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .bias       (bias),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_scores (out_scores),
        .err_len    (err_len)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic signed [FEAT_W-1:0] d, input logic l, input int idx);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        check($sformatf("w_addr_f%0d", idx), 32'(w_addr), idx);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic load_basic();
        logic [WGT_W*N_OUT-1:0] r;
        for (int k = 0; k < N_OUT; k++) r[WGT_W*k +: WGT_W] = WGT_W'(k);
        for (int i = 0; i < N_IN; i++) wmem[i] = r;
        for (int k = 0; k < N_OUT; k++) bias[k] = '0;
    endtask

    task automatic check_basic(input string tag);
        for (int k = 0; k < N_OUT; k++)
            check($sformatf("%s_s%0d", tag, k), out_scores[k], 10 * k);
    endtask

    function automatic int argmax_idx();
        int best = 0;
        for (int k = 1; k < N_OUT; k++)
            if (out_scores[k] > out_scores[best]) best = k;
        return best;
    endfunction

    initial begin
        logic [WGT_W*N_OUT-1:0] r;
        load_basic();

        // Reset values, during reset and in the cycle after release
        repeat (2) tick();
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_err_len", 32'(err_len), 0);
        check("rst_w_addr", 32'(w_addr), 0);
        check("rst_score0", out_scores[0], 0);
        rst = 1'b0;
        check("post_rst_in_ready", 32'(in_ready), 1);
        check("post_rst_out_valid", 32'(out_valid), 0);

        // Basic scores: features 1..4, w[k]=k, bias 0 -> 10k
        feed(1, 0, 0);
        feed(2, 0, 1);
        feed(3, 0, 2);
        feed(4, 1, 3);
        check("drain_out_valid", 32'(out_valid), 0);
        check("drain_in_ready", 32'(in_ready), 0);
        tick();
        check("basic_out_valid", 32'(out_valid), 1);
        check_basic("basic");
        check("basic_argmax", argmax_idx(), 7);
        check("basic_err_len", 32'(err_len), 0);
        tick();
        check("basic_hs_in_ready", 32'(in_ready), 1);
        check("basic_hs_out_valid", 32'(out_valid), 0);

        // Bias, ReLU and output backpressure
        for (int k = 0; k < N_OUT; k++) r[WGT_W*k +: WGT_W] = WGT_W'(k);
        r[7:0]  = 8'hFF;
        r[15:8] = 8'h00;
        for (int i = 0; i < N_IN; i++) wmem[i] = r;
        bias[0]   = 3;
        bias[1]   = 100;
        out_ready = 1'b0;
        for (int i = 0; i < N_IN; i++) feed(5, (i == N_IN - 1), i);
        tick();
        check("bias_out_valid", 32'(out_valid), 1);
        check("relu_s0", out_scores[0], 0);
        check("bias_s1", out_scores[1], 100);
        check("bias_s2", out_scores[2], 40);
        check("bias_s7", out_scores[7], 140);
        in_valid = 1'b1;
        in_data  = 7;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("bp%0d_out_valid", c), 32'(out_valid), 1);
            check($sformatf("bp%0d_in_ready", c), 32'(in_ready), 0);
            check($sformatf("bp%0d_s0", c), out_scores[0], 0);
            check($sformatf("bp%0d_s1", c), out_scores[1], 100);
            check($sformatf("bp%0d_w_addr", c), 32'(w_addr), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_hs_in_ready", 32'(in_ready), 1);
        check("bp_hs_out_valid", 32'(out_valid), 0);
        load_basic();

        // Input bubbles between features
        feed(1, 0, 0);
        tick();
        check("bubble_w_addr0", 32'(w_addr), 1);
        feed(2, 0, 1);
        tick();
        check("bubble_w_addr1", 32'(w_addr), 2);
        feed(3, 0, 2);
        tick();
        feed(4, 1, 3);
        tick();
        check("bubble_out_valid", 32'(out_valid), 1);
        check_basic("bubble");
        tick();

        // Early in_last: sticky err_len, frame still runs for N_IN features
        feed(1, 0, 0);
        check("early_err_before", 32'(err_len), 0);
        feed(2, 1, 1);
        check("early_err_set", 32'(err_len), 1);
        feed(3, 0, 2);
        check("early_err_hold", 32'(err_len), 1);
        check("early_in_ready", 32'(in_ready), 1);
        feed(4, 0, 3);
        tick();
        check("early_out_valid", 32'(out_valid), 1);
        check_basic("early");
        check("early_err_sticky", 32'(err_len), 1);
        tick();

        // Reset mid-frame discards the partial frame
        feed(9, 0, 0);
        feed(9, 0, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_in_ready", 32'(in_ready), 1);
        check("midrst_err_len", 32'(err_len), 0);
        check("midrst_w_addr", 32'(w_addr), 0);
        feed(1, 0, 0);
        feed(2, 0, 1);
        feed(3, 0, 2);
        feed(4, 1, 3);
        tick();
        check("midrst_frame_valid", 32'(out_valid), 1);
        check_basic("midrst");
        check("midrst_frame_err", 32'(err_len), 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
